// File: rtl/host_spi_gram_loader.sv
// rtl/host_spi_gram_loader.sv - host SPI command decoder that streams or clears GRAM with single-cycle write strobes
module host_spi_gram_loader #(
    parameter int         MEM_BYTES = 3003,
    parameter int         ADDR_W    = 12,
    parameter logic [7:0] CMD_WRITE = 8'hA0,
    parameter logic [7:0] CMD_CLEAR = 8'hA1,
    parameter logic [7:0] FILL_VAL  = 8'h00
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              SSCK,
    input  logic              SSI,
    input  logic              SCS,
    output logic [ADDR_W-1:0] W_ADDR,
    output logic [7:0]        W_DATA,
    output logic              W_EN,
    output logic              BUSY,
    output logic              FRAME_DONE,
    output logic              OVF,
    output logic              HOST_SEL
);

    localparam logic [ADDR_W-1:0] ADDR_END  = ADDR_W'(MEM_BYTES);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(MEM_BYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_WRITE,
        S_FILL,
        S_DRAIN
    } state_t;

    state_t state, state_nxt;

    // [0]=first stage, [1]=synchronized level, [2]=previous level for edge detect
    logic [2:0] sck_sync;
    logic [2:0] scs_sync;
    logic [1:0] ssi_sync;

    logic [2:0]        bit_cnt, bit_cnt_nxt;
    logic [6:0]        shreg, shreg_nxt;
    logic [ADDR_W-1:0] addr, addr_nxt;
    logic              ovf_nxt;
    logic              w_en_nxt, done_nxt, busy_nxt;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic [7:0]        w_data_nxt;

    logic       sck_rise, scs_rise, scs_fall, ssi_bit;
    logic       take_bit, byte_done;
    logic [7:0] rx_byte;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sck_sync <= 3'b000;
            scs_sync <= 3'b111;
            ssi_sync <= 2'b00;
        end else begin
            sck_sync <= {sck_sync[1:0], SSCK};
            scs_sync <= {scs_sync[1:0], SCS};
            ssi_sync <= {ssi_sync[0], SSI};
        end
    end

    assign sck_rise = sck_sync[1] & ~sck_sync[2];
    assign scs_rise = scs_sync[1] & ~scs_sync[2];
    assign scs_fall = ~scs_sync[1] & scs_sync[2];
    assign ssi_bit  = ssi_sync[1];

    // A clock edge coinciding with deselect is dropped so the deselect is handled cleanly
    assign take_bit  = sck_rise & ~scs_rise & ((state == S_CMD) || (state == S_WRITE));
    assign byte_done = take_bit & (bit_cnt == 3'd7);
    assign rx_byte   = {shreg, ssi_bit};

    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt;
        shreg_nxt   = shreg;
        addr_nxt    = addr;
        ovf_nxt     = OVF;
        w_en_nxt    = 1'b0;
        w_addr_nxt  = '0;
        w_data_nxt  = 8'h00;
        done_nxt    = 1'b0;
        busy_nxt    = 1'b0;

        if (take_bit) begin
            bit_cnt_nxt = bit_cnt + 3'd1;
            shreg_nxt   = rx_byte[6:0];
        end

        case (state)
            S_IDLE: begin
                if (scs_fall) begin
                    state_nxt   = S_CMD;
                    bit_cnt_nxt = 3'd0;
                    shreg_nxt   = 7'd0;
                    addr_nxt    = '0;
                    ovf_nxt     = 1'b0;
                end
            end
            S_CMD: begin
                if (scs_rise) begin
                    state_nxt = S_IDLE;
                end else if (byte_done) begin
                    addr_nxt = '0;
                    if (rx_byte == CMD_WRITE) begin
                        state_nxt = S_WRITE;
                    end else if (rx_byte == CMD_CLEAR) begin
                        state_nxt = S_FILL;
                    end else begin
                        state_nxt = S_DRAIN;
                    end
                end
            end
            S_WRITE: begin
                if (scs_rise) begin
                    state_nxt = S_IDLE;
                    done_nxt  = 1'b1;
                end else if (byte_done) begin
                    if (addr == ADDR_END) begin
                        ovf_nxt = 1'b1;
                    end else begin
                        w_en_nxt   = 1'b1;
                        w_addr_nxt = addr;
                        w_data_nxt = {2'b00, rx_byte[5:0]};
                        addr_nxt   = addr + 1'b1;
                    end
                end
            end
            S_FILL: begin
                busy_nxt   = 1'b1;
                w_en_nxt   = 1'b1;
                w_addr_nxt = addr;
                w_data_nxt = {2'b00, FILL_VAL[5:0]};
                if (addr == ADDR_LAST) begin
                    done_nxt  = 1'b1;
                    addr_nxt  = '0;
                    state_nxt = scs_sync[1] ? S_IDLE : S_DRAIN;
                end else begin
                    addr_nxt = addr + 1'b1;
                end
            end
            S_DRAIN: begin
                if (scs_rise) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= S_IDLE;
            bit_cnt    <= 3'd0;
            shreg      <= 7'd0;
            addr       <= '0;
            OVF        <= 1'b0;
            W_EN       <= 1'b0;
            W_ADDR     <= '0;
            W_DATA     <= 8'h00;
            FRAME_DONE <= 1'b0;
            BUSY       <= 1'b0;
            HOST_SEL   <= 1'b0;
        end else begin
            state      <= state_nxt;
            bit_cnt    <= bit_cnt_nxt;
            shreg      <= shreg_nxt;
            addr       <= addr_nxt;
            OVF        <= ovf_nxt;
            W_EN       <= w_en_nxt;
            W_ADDR     <= w_addr_nxt;
            W_DATA     <= w_data_nxt;
            FRAME_DONE <= done_nxt;
            BUSY       <= busy_nxt;
            HOST_SEL   <= ~scs_sync[1];
        end
    end

endmodule

// File: tb/tb_host_spi_gram_loader.sv
// tb/tb_host_spi_gram_loader.sv - self-checking bench for host_spi_gram_loader
module tb_host_spi_gram_loader;

    localparam int MEM  = 37;
    localparam int HALF = 4;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        SSCK = 1'b0;
    logic        SSI = 1'b0;
    logic        SCS = 1'b1;
    logic [11:0] W_ADDR;
    logic [7:0]  W_DATA;
    logic        W_EN, BUSY, FRAME_DONE, OVF, HOST_SEL;

    always #5 CLK = ~CLK;

    host_spi_gram_loader #(.MEM_BYTES(MEM), .ADDR_W(12)) dut (
        .CLK(CLK), .RST(RST), .SSCK(SSCK), .SSI(SSI), .SCS(SCS),
        .W_ADDR(W_ADDR), .W_DATA(W_DATA), .W_EN(W_EN), .BUSY(BUSY),
        .FRAME_DONE(FRAME_DONE), .OVF(OVF), .HOST_SEL(HOST_SEL)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [11:0] wa_q[$];
    logic [7:0]  wd_q[$];
    int          done_cnt = 0, busy_cnt = 0, viol_cnt = 0;

    logic [7:0]  tx_q[$];
    logic [11:0] ea_q[$];
    logic [7:0]  ed_q[$];
    int          e_done, e_busy;
    logic        e_ovf;

    always @(negedge CLK) begin
        if (!RST) begin
            if (W_EN) begin
                wa_q.push_back(W_ADDR);
                wd_q.push_back(W_DATA);
                if (W_DATA[7:6] != 2'b00) viol_cnt++;
            end else if (W_ADDR != 12'd0) begin
                viol_cnt++;
            end
            if (FRAME_DONE) done_cnt++;
            if (BUSY) busy_cnt++;
        end
    end

    function automatic bit chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
            return 1'b0;
        end
        return 1'b1;
    endfunction

    // Expected GRAM traffic from the command rules, independent of timing
    function automatic void build_model(input logic [7:0] cmd, input int cmd_bits);
        ea_q.delete();
        ed_q.delete();
        e_done = 0;
        e_busy = 0;
        e_ovf  = 1'b0;
        if (cmd_bits == 8) begin
            if (cmd == 8'hA0) begin
                e_done = 1;
                for (int i = 0; i < tx_q.size(); i++) begin
                    if (i < MEM) begin
                        ea_q.push_back(12'(i));
                        ed_q.push_back(tx_q[i] & 8'h3F);
                    end else begin
                        e_ovf = 1'b1;
                    end
                end
            end else if (cmd == 8'hA1) begin
                e_done = 1;
                e_busy = MEM;
                for (int i = 0; i < MEM; i++) begin
                    ea_q.push_back(12'(i));
                    ed_q.push_back(8'h00);
                end
            end
        end
    endfunction

    task automatic send_bit(input logic b);
        SSI = b;
        repeat (HALF) @(negedge CLK);
        SSCK = 1'b1;
        repeat (HALF) @(negedge CLK);
        SSCK = 1'b0;
    endtask

    task automatic send_bits(input logic [7:0] v, input int n);
        for (int i = 0; i < n; i++) send_bit(v[7-i]);
    endtask

    task automatic clear_logs();
        wa_q.delete();
        wd_q.delete();
        done_cnt = 0;
        busy_cnt = 0;
    endtask

    task automatic run_txn(input logic [7:0] cmd, input int cmd_bits, input int extra, input string tag);
        clear_logs();
        build_model(cmd, cmd_bits);
        SCS = 1'b0;
        repeat (6) @(negedge CLK);
        void'(chk({tag, "_hostsel_lo"}, 32'(HOST_SEL), 32'd1));
        send_bits(cmd, cmd_bits);
        foreach (tx_q[i]) send_bits(tx_q[i], 8);
        send_bits(8'($urandom), extra);
        repeat (6) @(negedge CLK);
        SCS = 1'b1;
        repeat (MEM + 20) @(negedge CLK);
        if (chk({tag, "_nwrites"}, 32'(wa_q.size()), 32'(ea_q.size()))) begin
            for (int i = 0; i < ea_q.size(); i++) begin
                if (!chk({tag, "_write"}, {wa_q[i], wd_q[i]}, {ea_q[i], ed_q[i]})) break;
            end
        end
        void'(chk({tag, "_done"}, 32'(done_cnt), 32'(e_done)));
        void'(chk({tag, "_ovf"}, 32'(OVF), 32'(e_ovf)));
        void'(chk({tag, "_busy"}, 32'(busy_cnt), 32'(e_busy)));
        void'(chk({tag, "_hostsel_hi"}, 32'(HOST_SEL), 32'd0));
        void'(chk({tag, "_viol"}, 32'(viol_cnt), 32'd0));
    endtask

    typedef struct {
        logic [7:0] cmd;
        int         cmd_bits;
        int         nbytes;
        logic [7:0] base;
        logic [7:0] step;
        int         extra;
        int         exp_wr;
        int         exp_done;
        logic       exp_ovf;
    } vec_t;

    vec_t vt[8];

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{8'hA0, 8, 3,       8'h11, 8'h11, 0, 3,   1, 1'b0};
        vt[1] = '{8'hA0, 8, MEM + 2, 8'hFF, 8'h00, 0, MEM, 1, 1'b1};
        vt[2] = '{8'hA1, 8, 0,       8'h00, 8'h00, 0, MEM, 1, 1'b0};
        vt[3] = '{8'hA0, 8, 1,       8'hAB, 8'h00, 5, 1,   1, 1'b0};
        vt[4] = '{8'hA0, 8, 2,       8'hC1, 8'h01, 0, 2,   1, 1'b0};
        vt[5] = '{8'h55, 8, 2,       8'h12, 8'h22, 0, 0,   0, 1'b0};
        vt[6] = '{8'hA0, 5, 0,       8'h00, 8'h00, 0, 0,   0, 1'b0};
        vt[7] = '{8'hA1, 8, 3,       8'h5A, 8'h01, 0, MEM, 1, 1'b0};

        repeat (3) @(negedge CLK);
        void'(chk("rst_w_en", 32'(W_EN), 32'd0));
        void'(chk("rst_w_addr", 32'(W_ADDR), 32'd0));
        void'(chk("rst_w_data", 32'(W_DATA), 32'd0));
        void'(chk("rst_busy", 32'(BUSY), 32'd0));
        void'(chk("rst_frame_done", 32'(FRAME_DONE), 32'd0));
        void'(chk("rst_ovf", 32'(OVF), 32'd0));
        void'(chk("rst_host_sel", 32'(HOST_SEL), 32'd0));
        RST = 1'b0;
        repeat (5) @(negedge CLK);

        foreach (vt[k]) begin
            tx_q.delete();
            for (int i = 0; i < vt[k].nbytes; i++) tx_q.push_back(vt[k].base + 8'(i) * vt[k].step);
            run_txn(vt[k].cmd, vt[k].cmd_bits, vt[k].extra, $sformatf("vec%0d", k));
            void'(chk($sformatf("vec%0d_tbl_wr", k), 32'(wa_q.size()), 32'(vt[k].exp_wr)));
            void'(chk($sformatf("vec%0d_tbl_done", k), 32'(done_cnt), 32'(vt[k].exp_done)));
            void'(chk($sformatf("vec%0d_tbl_ovf", k), 32'(OVF), 32'(vt[k].exp_ovf)));
        end

        // Sticky overflow clears on the next chip-select fall
        tx_q.delete();
        for (int i = 0; i < MEM + 1; i++) tx_q.push_back(8'(i));
        run_txn(8'hA0, 8, 0, "ovf_set");
        SCS = 1'b0;
        repeat (6) @(negedge CLK);
        void'(chk("ovf_clear_on_cs", 32'(OVF), 32'd0));
        SCS = 1'b1;
        repeat (10) @(negedge CLK);

        // Reset in the middle of a clear fill
        begin
            int t;
            clear_logs();
            SCS = 1'b0;
            repeat (6) @(negedge CLK);
            send_bits(8'hA1, 8);
            t = 0;
            while (!(W_EN && W_ADDR == 12'(MEM / 2)) && t < 500) begin
                @(negedge CLK);
                t++;
            end
            void'(chk("rstfill_reached", 32'(t < 500), 32'd1));
            #1;
            RST = 1'b1;
            SCS = 1'b1;
            @(negedge CLK);
            void'(chk("rstfill_w_en", 32'(W_EN), 32'd0));
            void'(chk("rstfill_w_addr", 32'(W_ADDR), 32'd0));
            void'(chk("rstfill_busy", 32'(BUSY), 32'd0));
            void'(chk("rstfill_done", 32'(FRAME_DONE), 32'd0));
            void'(chk("rstfill_host_sel", 32'(HOST_SEL), 32'd0));
            void'(chk("rstfill_nwrites", 32'(wa_q.size()), 32'(MEM / 2 + 1)));
            repeat (5) @(negedge CLK);
            RST = 1'b0;
            repeat (5) @(negedge CLK);
            tx_q.delete();
            tx_q.push_back(8'h11);
            tx_q.push_back(8'h22);
            run_txn(8'hA0, 8, 0, "after_rst");
        end

        // Randomized transactions against the reference model
        for (int n = 0; n < 10; n++) begin
            logic [7:0] cmd;
            int         r, cbits, nb, extra;
            r = $urandom_range(0, 9);
            cmd = (r < 5) ? 8'hA0 : (r < 7) ? 8'hA1 : 8'($urandom_range(0, 255));
            cbits = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 7) : 8;
            nb = (cmd == 8'hA0) ? $urandom_range(0, MEM + 3) : $urandom_range(0, 3);
            extra = $urandom_range(0, 7);
            if (cbits != 8) begin
                nb = 0;
                extra = 0;
            end
            tx_q.delete();
            for (int i = 0; i < nb; i++) tx_q.push_back(8'($urandom));
            run_txn(cmd, cbits, extra, $sformatf("rnd%0d", n));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
